instruction_loader: RTL and testbench

- Byte-stream program loader that writes the instruction memory the MiniAlu core fetches from.
- Receives bytes over a valid/ready handshake and assembles them into 28-bit instruction words.
- Writes each word into the instruction RAM write port, then verifies a trailing XOR checksum byte.
- Holds the core in reset until a load completes with a good checksum.

---
 rtl/instruction_loader_pkg.sv | 20 ++
 rtl/loader_byte_assembler.sv | 54 +++++
 rtl/instruction_loader.sv | 159 +++++++++++++++
 tb/tb_instruction_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader.
// Holds the FSM state encoding and the instruction word geometry constants
// used by instruction_loader and loader_byte_assembler.
package instruction_loader_pkg;

    localparam int INSTR_WIDTH     = 28;
    localparam int BYTES_PER_INSTR = 4;
    // Width of the byte assembly register (one full word of stream bytes).
    localparam int ASM_WIDTH       = 8 * BYTES_PER_INSTR;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

endpackage

// File: rtl/loader_byte_assembler.sv
// Byte assembler for the instruction loader.
// Shifts accepted stream bytes into a word register (first byte ends up most
// significant), counts bytes within the current word and keeps a running XOR
// checksum over every byte shifted in.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clear      - synchronous clear of word, byte count and checksum
//   shift_en   - shift byte_in in this cycle
//   byte_in    - stream byte
//   word       - word as it will be once byte_in is shifted in
//   checksum   - XOR of all bytes shifted in since the last clear
//   last_byte  - the next shifted byte completes a word
module loader_byte_assembler
    import instruction_loader_pkg::*;
#(
    parameter int BYTES = BYTES_PER_INSTR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [7:0]           byte_in,
    output logic [ASM_WIDTH-1:0] word,
    output logic [7:0]           checksum,
    output logic                 last_byte
);

    logic [ASM_WIDTH-1:0] word_reg;
    logic [1:0]           count_reg;
    logic [7:0]           checksum_reg;

    // Exposing the post-shift word lets the parent register the finished
    // instruction on the same edge that accepts the final byte.
    assign word      = (word_reg << 8) | ASM_WIDTH'(byte_in);
    assign checksum  = checksum_reg;
    assign last_byte = (count_reg == 2'(BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg     <= '0;
            count_reg    <= '0;
            checksum_reg <= '0;
        end else if (clear) begin
            word_reg     <= '0;
            count_reg    <= '0;
            checksum_reg <= '0;
        end else if (shift_en) begin
            word_reg     <= word;
            count_reg    <= count_reg + 2'd1;  // wraps naturally at a word boundary
            checksum_reg <= checksum_reg ^ byte_in;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Byte-stream program loader for the MiniAlu instruction memory.
// Assembles 4 stream bytes per instruction, writes each word to the
// instruction RAM, then checks a trailing XOR checksum byte. The core is
// held in reset until a load finishes with a good checksum.
// Ports:
//   Clock, Reset   - clock, asynchronous active-high reset
//   iStart/iLength - start a load of iLength words (IDLE/DONE/ERROR only)
//   iByte, iByteValid, oByteReady - byte stream handshake
//   oWriteEnable, oWriteAddress, oInstruction - instruction RAM write port
//   oCpuReset      - core reset, released only after a good load
//   oDone, oError  - load completed with good / bad checksum
module instruction_loader #(
    parameter int ADDR_WIDTH      = 16,
    parameter int INSTR_WIDTH     = instruction_loader_pkg::INSTR_WIDTH,
    parameter int BYTES_PER_INSTR = instruction_loader_pkg::BYTES_PER_INSTR
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iStart,
    input  logic [ADDR_WIDTH-1:0]  iLength,
    input  logic [7:0]             iByte,
    input  logic                   iByteValid,
    output logic                   oByteReady,
    output logic                   oWriteEnable,
    output logic [ADDR_WIDTH-1:0]  oWriteAddress,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic                   oCpuReset,
    output logic                   oDone,
    output logic                   oError
);

    import instruction_loader_pkg::*;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  length_reg, length_next;
    logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
    logic                   byte_ready_reg, byte_ready_next;
    logic                   write_enable_reg, write_enable_next;
    logic                   cpu_reset_reg, cpu_reset_next;
    logic                   done_reg, done_next;
    logic                   error_reg, error_next;

    logic                   byte_accept;
    logic                   asm_clear;
    logic                   asm_shift;
    logic [ASM_WIDTH-1:0]   asm_word;
    logic [7:0]             asm_checksum;
    logic                   asm_last;

    assign byte_accept = iByteValid & byte_ready_reg;
    assign asm_shift   = byte_accept && (state_reg == ST_RECV);

    loader_byte_assembler #(
        .BYTES (BYTES_PER_INSTR)
    ) u_assembler (
        .clk       (Clock),
        .rst       (Reset),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .byte_in   (iByte),
        .word      (asm_word),
        .checksum  (asm_checksum),
        .last_byte (asm_last)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg        <= ST_IDLE;
            length_reg       <= '0;
            addr_reg         <= '0;
            instr_reg        <= '0;
            byte_ready_reg   <= 1'b0;
            write_enable_reg <= 1'b0;
            cpu_reset_reg    <= 1'b1;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            length_reg       <= length_next;
            addr_reg         <= addr_next;
            instr_reg        <= instr_next;
            byte_ready_reg   <= byte_ready_next;
            write_enable_reg <= write_enable_next;
            cpu_reset_reg    <= cpu_reset_next;
            done_reg         <= done_next;
            error_reg        <= error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        length_next    = length_reg;
        addr_next      = addr_reg;
        instr_next     = instr_reg;
        cpu_reset_next = cpu_reset_reg;
        done_next      = done_reg;
        error_next     = error_reg;
        asm_clear      = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (iStart) begin
                    length_next    = iLength;
                    addr_next      = '0;
                    done_next      = 1'b0;
                    error_next     = 1'b0;
                    cpu_reset_next = 1'b1;
                    asm_clear      = 1'b1;
                    // A zero-length load goes straight to the checksum byte.
                    state_next     = (iLength != '0) ? ST_RECV : ST_CHECK;
                end
            end
            ST_RECV: begin
                if (byte_accept && asm_last) begin
                    // The top nibble of the first byte is dropped here.
                    instr_next = INSTR_WIDTH'(asm_word);
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (addr_reg == length_reg - ADDR_WIDTH'(1)) begin
                    state_next = ST_CHECK;
                end else begin
                    addr_next  = addr_reg + ADDR_WIDTH'(1);
                    state_next = ST_RECV;
                end
            end
            ST_CHECK: begin
                if (byte_accept) begin
                    if (iByte == asm_checksum) begin
                        done_next      = 1'b1;
                        cpu_reset_next = 1'b0;
                        state_next     = ST_DONE;
                    end else begin
                        error_next     = 1'b1;
                        cpu_reset_next = 1'b1;
                        state_next     = ST_ERROR;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Handshake and write strobe are registered, so derive them from the
        // state being entered rather than the current one.
        byte_ready_next   = (state_next == ST_RECV) || (state_next == ST_CHECK);
        write_enable_next = (state_next == ST_WRITE);
    end

    assign oByteReady    = byte_ready_reg;
    assign oWriteEnable  = write_enable_reg;
    assign oWriteAddress = addr_reg;
    assign oInstruction  = instr_reg;
    assign oCpuReset     = cpu_reset_reg;
    assign oDone         = done_reg;
    assign oError        = error_reg;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

    logic        Clock;
    logic        Reset;
    logic        iStart;
    logic [15:0] iLength;
    logic [7:0]  iByte;
    logic        iByteValid;
    logic        oByteReady;
    logic        oWriteEnable;
    logic [15:0] oWriteAddress;
    logic [27:0] oInstruction;
    logic        oCpuReset;
    logic        oDone;
    logic        oError;

    instruction_loader #(
        .ADDR_WIDTH      (16),
        .INSTR_WIDTH     (28),
        .BYTES_PER_INSTR (4)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iStart        (iStart),
        .iLength       (iLength),
        .iByte         (iByte),
        .iByteValid    (iByteValid),
        .oByteReady    (oByteReady),
        .oWriteEnable  (oWriteEnable),
        .oWriteAddress (oWriteAddress),
        .oInstruction  (oInstruction),
        .oCpuReset     (oCpuReset),
        .oDone         (oDone),
        .oError        (oError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] addr;
        logic [27:0] data;
    } wr_t;

    wr_t        sb_wr[$];
    logic [2:0] sb_st[$];   // {oDone, oError, oCpuReset}

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  stream   [8];
    logic [27:0] exp_data [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"},  32'(oByteReady),    32'd0);
        chk({tag, "_we"},     32'(oWriteEnable),  32'd0);
        chk({tag, "_addr"},   32'(oWriteAddress), 32'd0);
        chk({tag, "_instr"},  32'(oInstruction),  32'd0);
        chk({tag, "_cpurst"}, 32'(oCpuReset),     32'd1);
        chk({tag, "_done"},   32'(oDone),         32'd0);
        chk({tag, "_error"},  32'(oError),        32'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a
    // new completion status.
    initial begin
        logic prev_flag;
        logic flag;
        wr_t  w;
        logic [2:0] st;
        prev_flag = 1'b0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                prev_flag = 1'b0;
            end else begin
                if (oWriteEnable) begin
                    if (sb_wr.size() == 0) begin
                        chk("unexpected_write", 32'(oWriteAddress), 32'hFFFF_FFFF);
                    end else begin
                        w = sb_wr.pop_front();
                        $display("write addr=%0h data=%07h (expect addr=%0h data=%07h)",
                                 oWriteAddress, oInstruction, w.addr, w.data);
                        chk("write_addr", 32'(oWriteAddress), 32'(w.addr));
                        chk("write_data", 32'(oInstruction), 32'(w.data));
                        chk("ready_in_write", 32'(oByteReady), 32'd0);
                    end
                end
                flag = oDone | oError;
                if (flag && !prev_flag) begin
                    if (sb_st.size() == 0) begin
                        chk("unexpected_status", 32'({oDone, oError, oCpuReset}), 32'hFFFF_FFFF);
                    end else begin
                        st = sb_st.pop_front();
                        $display("status done=%0b error=%0b cpu_reset=%0b (expect %03b)",
                                 oDone, oError, oCpuReset, st);
                        chk("status", 32'({oDone, oError, oCpuReset}), 32'(st));
                    end
                end
                prev_flag = flag;
            end
        end
    end

    task automatic do_start(input logic [15:0] len);
        iStart  = 1'b1;
        iLength = len;
        @(negedge Clock);
        iStart  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        iByte      = b;
        iByteValid = 1'b1;
        k = 0;
        while (!oByteReady && k < 50) begin
            @(negedge Clock);
            k++;
        end
        if (k >= 50) chk("byte_ready_timeout", 32'(k), 32'd0);
        @(negedge Clock);
        iByteValid = 1'b0;
        repeat (gap) @(negedge Clock);
    endtask

    task automatic wait_status();
        int k;
        k = 0;
        while (sb_st.size() != 0 && k < 100) begin
            @(negedge Clock);
            k++;
        end
        chk("status_pending", 32'(sb_st.size()), 32'd0);
    endtask

    task automatic run_stream(input logic [7:0] csum, input int gap,
                              input bit mid_start, input bit good);
        wr_t w;
        do_start(16'd2);
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3) begin
                w.addr = 16'(i / 4);
                w.data = exp_data[i / 4];
                sb_wr.push_back(w);
            end
            send_byte(stream[i], gap);
            if (mid_start && i == 1) begin
                iStart  = 1'b1;
                iLength = 16'd5;
                @(negedge Clock);
                iStart  = 1'b0;
                iLength = 16'd2;
            end
        end
        sb_st.push_back(good ? 3'b100 : 3'b011);
        send_byte(csum, gap);
        wait_status();
        chk("writes_drained", 32'(sb_wr.size()), 32'd0);
        chk("final_addr", 32'(oWriteAddress), 32'd1);
    endtask

    initial begin
        stream[0] = 8'h0A; stream[1] = 8'h12; stream[2] = 8'h34; stream[3] = 8'h56;
        stream[4] = 8'h01; stream[5] = 8'h00; stream[6] = 8'h00; stream[7] = 8'h07;
        exp_data[0] = 28'hA123456;
        exp_data[1] = 28'h1000007;

        Reset      = 1'b0;
        iStart     = 1'b0;
        iLength    = '0;
        iByte      = '0;
        iByteValid = 1'b0;

        // Reset asserted before any clock edge.
        #1 Reset = 1'b1;
        #1 chk_reset_values("por");
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        $display("load: good checksum");
        run_stream(8'h7C, 0, 1'b0, 1'b1);

        $display("load: bad checksum");
        run_stream(8'h7D, 0, 1'b0, 1'b0);

        $display("load: valid every other cycle");
        run_stream(8'h7C, 1, 1'b0, 1'b1);

        $display("load: reset mid word");
        do_start(16'd2);
        send_byte(8'h0A, 0);
        send_byte(8'h12, 0);
        #2 Reset = 1'b1;
        #1 chk_reset_values("midrst");
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        run_stream(8'h7C, 0, 1'b0, 1'b1);

        $display("load: zero length");
        do_start(16'd0);
        sb_st.push_back(3'b100);
        send_byte(8'h00, 0);
        wait_status();
        chk("zero_len_addr", 32'(oWriteAddress), 32'd0);

        $display("load: iStart during RECV");
        run_stream(8'h7C, 0, 1'b1, 1'b1);

        repeat (3) @(negedge Clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
